// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared types and defaults for the data-memory arbiter
package dmem_arbiter_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int WAIT_W = 4;
  typedef enum logic {ARB_CPU = 1'b0, ARB_EXT = 1'b1} arb_state_e;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, EXT and DataMemory signals of the arbiter; slave = arbiter view
interface dmem_arbiter_if import dmem_arbiter_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic cpu_req, cpu_we, cpu_stall;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic ext_req, ext_we, ext_gnt, ext_rvalid;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata, ext_rdata;
  logic mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  modport slave (
    input cpu_req, cpu_we, cpu_addr, cpu_wdata, ext_req, ext_we, ext_addr, ext_wdata, mem_rdata,
    output cpu_rdata, cpu_stall, ext_gnt, ext_rdata, ext_rvalid, mem_addr, mem_wdata, mem_we, mem_re
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, ext_req, ext_we, ext_addr, ext_wdata, mem_rdata,
    input cpu_rdata, cpu_stall, ext_gnt, ext_rdata, ext_rvalid, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/dmem_arb_wait_ctr.sv
// dmem_arb_wait_ctr: 4-bit saturating EXT wait counter; o_at_max flags the value it loads next
module dmem_arb_wait_ctr import dmem_arbiter_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_inc,
  input  logic              i_clr,
  input  logic [WAIT_W-1:0] i_max,
  output logic [WAIT_W-1:0] o_cnt,
  output logic              o_at_max
);
  logic [WAIT_W-1:0] r_cnt, w_nxt;
  // next count: clear wins, otherwise saturate at i_max
  always_comb begin
    w_nxt = i_clr ? '0 : !i_inc ? r_cnt : (r_cnt >= i_max) ? i_max : r_cnt + 1'b1;
    o_at_max = w_nxt == i_max;
  end
  // count register
  always_ff @(posedge clk) r_cnt <= rst ? '0 : w_nxt;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU-priority data-memory arbiter with forced EXT grant; DMEM_ARB_STATS_EN adds stall counter
module dmem_arbiter import dmem_arbiter_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus,
  output logic [15:0]   o_stat_stall
);
  arb_state_e r_state, w_state_nxt;
  logic w_ext_gnt, w_cpu_gnt, w_we, w_re, w_stall, w_at_max, w_ext_rd;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata, r_rdata;
  logic [WAIT_W-1:0] w_cnt;
  logic r_rvalid;
  dmem_arb_wait_ctr u_wait (
    .clk(clk),
    .rst(rst),
    .i_inc(bus.ext_req),
    .i_clr(w_ext_gnt | ~bus.ext_req),
    .i_max(WAIT_W'(MAX_WAIT)),
    .o_cnt(w_cnt),
    .o_at_max(w_at_max)
  );
  // grant priority: forced EXT, then CPU, then idle-port EXT; mem port follows the winner
  always_comb begin
    w_ext_gnt = bus.ext_req & ((r_state == ARB_EXT) | ~bus.cpu_req);
    w_cpu_gnt = bus.cpu_req & ~w_ext_gnt;
    w_stall = bus.cpu_req & w_ext_gnt;
    w_ext_rd = w_ext_gnt & ~bus.ext_we;
    w_addr = w_ext_gnt ? bus.ext_addr : w_cpu_gnt ? bus.cpu_addr : '0;
    w_wdata = w_ext_gnt ? bus.ext_wdata : w_cpu_gnt ? bus.cpu_wdata : '0;
    w_we = w_ext_gnt ? bus.ext_we : w_cpu_gnt & bus.cpu_we;
    w_re = w_ext_gnt ? ~bus.ext_we : w_cpu_gnt & ~bus.cpu_we;
    w_state_nxt = w_at_max ? ARB_EXT : ARB_CPU;
  end
  // arbitration state: forced grant only for the cycle after the wait saturates
  always_ff @(posedge clk) r_state <= rst ? ARB_CPU : w_state_nxt;
  // EXT read return: capture data at the end of the grant, pulse valid one cycle
  always_ff @(posedge clk) begin
    r_rvalid <= ~rst & w_ext_rd;
    r_rdata <= rst ? '0 : w_ext_rd ? bus.mem_rdata : r_rdata;
  end
  assign bus.ext_gnt = w_ext_gnt;
  assign bus.cpu_stall = w_stall;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.ext_rdata = r_rdata;
  assign bus.ext_rvalid = r_rvalid;
  assign bus.mem_addr = w_addr;
  assign bus.mem_wdata = w_wdata;
  assign bus.mem_we = w_we;
  assign bus.mem_re = w_re;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] r_stat;
  // saturating count of CPU stall cycles
  always_ff @(posedge clk) r_stat <= rst ? '0 : (w_stall && r_stat != 16'hFFFF) ? r_stat + 16'd1 : r_stat;
  assign o_stat_stall = r_stat;
`else
  assign o_stat_stall = '0;
`endif
  a_cnt_range: assert property (@(posedge clk) disable iff (rst) w_cnt <= WAIT_W'(MAX_WAIT));
endmodule
